// File: rtl/riscv_pkg.sv
// Shared RISC-V encodings: base opcodes and the 4-bit alu_control codes
// driven by the control decoder and consumed by the execute-stage ALU.
package riscv_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOP = 4'b1111;

endpackage

// File: rtl/alu_exec_unit_core.sv
// Combinational ALU datapath: maps (ctrl, a, b) to a result and flags
// control codes outside the defined set as illegal.
module alu_core
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [3:0]      ctrl,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] result,
    output logic            illegal
);

    logic lt;

    assign lt = $signed(a) < $signed(b);

    always_comb begin
        result  = '0;
        illegal = 1'b0;
        case (ctrl)
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_SLT: result = {{(XLEN-1){1'b0}}, lt};
            ALU_NOP: result = '0;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Two-stage execute ALU: S1 holds operands, S2 holds the registered result.
// Valid/ready on both sides; the whole pipe stalls on output back-pressure.
module alu_exec_unit
    import riscv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_ctrl,
    input  logic [XLEN-1:0]  in_a,
    input  logic [XLEN-1:0]  in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic             out_zero,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal,
    output logic [CNT_W-1:0] illegal_cnt
);

    logic             s1_valid;
    logic [3:0]       s1_ctrl;
    logic [XLEN-1:0]  s1_a;
    logic [XLEN-1:0]  s1_b;
    logic [TAG_W-1:0] s1_tag;
    logic             s2_valid;
    logic             adv1;
    logic             adv2;
    logic [XLEN-1:0]  core_result;
    logic             core_illegal;

    assign adv2      = !s2_valid || out_ready;
    assign adv1      = !s1_valid || adv2;
    assign in_ready  = adv1 && !rst && !flush;
    assign out_valid = s2_valid;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            s1_valid <= 1'b0;
        end else if (adv1) begin
            s1_valid <= in_valid;
        end
    end

    // Operand payload needs no reset; it is only observed behind s1_valid.
    always_ff @(posedge clk) begin
        if (in_valid && in_ready) begin
            s1_ctrl <= in_ctrl;
            s1_a    <= in_a;
            s1_b    <= in_b;
            s1_tag  <= in_tag;
        end
    end

    alu_core #(
        .XLEN(XLEN)
    ) u_core (
        .ctrl   (s1_ctrl),
        .a      (s1_a),
        .b      (s1_b),
        .result (core_result),
        .illegal(core_illegal)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid    <= 1'b0;
            out_result  <= '0;
            out_zero    <= 1'b0;
            out_tag     <= '0;
            out_illegal <= 1'b0;
            illegal_cnt <= '0;
        end else if (flush) begin
            s2_valid <= 1'b0;
        end else if (adv2) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                out_result  <= core_result;
                out_zero    <= (core_result == '0);
                out_tag     <= s1_tag;
                out_illegal <= core_illegal;
                // Saturate rather than wrap so a burst never reads as few.
                if (core_illegal && (illegal_cnt != '1)) begin
                    illegal_cnt <= illegal_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit; a second instance with a
// 2-bit counter shares the stimulus to exercise counter saturation.
module tb_alu_exec_unit;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_ctrl;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [4:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_zero;
    logic [4:0]  out_tag;
    logic        out_illegal;
    logic [15:0] illegal_cnt;

    logic        in_ready2;
    logic        out_valid2;
    logic [31:0] out_result2;
    logic        out_zero2;
    logic [4:0]  out_tag2;
    logic        out_illegal2;
    logic [1:0]  illegal_cnt2;

    int n_chk;
    int n_fail;

    alu_exec_unit #(.XLEN(32), .TAG_W(5), .CNT_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_ctrl    (in_ctrl),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_zero   (out_zero),
        .out_tag    (out_tag),
        .out_illegal(out_illegal),
        .illegal_cnt(illegal_cnt)
    );

    alu_exec_unit #(.XLEN(32), .TAG_W(5), .CNT_W(2)) dut2 (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready2),
        .in_ctrl    (in_ctrl),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_tag     (in_tag),
        .out_valid  (out_valid2),
        .out_ready  (out_ready),
        .out_result (out_result2),
        .out_zero   (out_zero2),
        .out_tag    (out_tag2),
        .out_illegal(out_illegal2),
        .illegal_cnt(illegal_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        in_ctrl = 4'b0;
        in_a = '0;
        in_b = '0;
        in_tag = '0;
        next_cycle();
        @(negedge clk);
        n_chk++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_in_ready got %b exp 0", in_ready);
        end
        n_chk++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_out_valid got %b exp 0", out_valid);
        end
        n_chk++;
        if (out_result !== 32'h0 || out_zero !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_result got %h/%b exp 0/0", out_result, out_zero);
        end
        n_chk++;
        if (out_tag !== 5'h0 || out_illegal !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_tag_ill got %h/%b exp 0/0", out_tag, out_illegal);
        end
        n_chk++;
        if (illegal_cnt !== 16'h0 || illegal_cnt2 !== 2'h0) begin
            n_fail++;
            $display("FAIL rst_cnt got %h/%h exp 0/0", illegal_cnt, illegal_cnt2);
        end
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        n_chk++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_release_in_ready got %b exp 1", in_ready);
        end
        next_cycle();
    endtask

    task automatic test_back_to_back;
        logic [3:0]  ctl [5] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0111};
        logic [31:0] opa [5] = '{32'd7, 32'd5, 32'hF0, 32'hF0, 32'hFFFFFFFF};
        logic [31:0] opb [5] = '{32'd5, 32'd7, 32'h3C, 32'h0F, 32'd1};
        logic [31:0] exp [5] = '{32'd12, 32'hFFFFFFFE, 32'h30, 32'hFF, 32'd1};
        out_ready = 1'b1;
        for (int c = 0; c < 7; c++) begin
            if (c < 5) begin
                in_valid = 1'b1;
                in_ctrl = ctl[c];
                in_a = opa[c];
                in_b = opb[c];
                in_tag = 5'(c + 1);
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (c < 5) begin
                n_chk++;
                if (in_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL b2b_in_ready c=%0d got %b exp 1", c, in_ready);
                end
            end
            if (c < 2) begin
                n_chk++;
                if (out_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL b2b_early_valid c=%0d got %b exp 0", c, out_valid);
                end
            end else begin
                n_chk++;
                if (out_valid !== 1'b1 || out_result !== exp[c-2] ||
                    out_tag !== 5'(c - 1) || out_illegal !== 1'b0) begin
                    n_fail++;
                    $display("FAIL b2b_result c=%0d got v=%b r=%h t=%0d i=%b exp v=1 r=%h t=%0d i=0",
                             c, out_valid, out_result, out_tag, out_illegal, exp[c-2], c - 1);
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_wrap_zero;
        logic [3:0]  ctl [3] = '{4'b0010, 4'b0110, 4'b0111};
        logic [31:0] opa [3] = '{32'hFFFFFFFF, 32'd9, 32'd1};
        logic [31:0] opb [3] = '{32'd1, 32'd9, 32'hFFFFFFFF};
        out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            if (c < 3) begin
                in_valid = 1'b1;
                in_ctrl = ctl[c];
                in_a = opa[c];
                in_b = opb[c];
                in_tag = 5'(c + 8);
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (c >= 2) begin
                n_chk++;
                if (out_valid !== 1'b1 || out_result !== 32'h0 || out_zero !== 1'b1 ||
                    out_tag !== 5'(c + 6)) begin
                    n_fail++;
                    $display("FAIL wrap_zero c=%0d got v=%b r=%h z=%b t=%0d exp v=1 r=0 z=1 t=%0d",
                             c, out_valid, out_result, out_zero, out_tag, c + 6);
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_back_pressure;
        logic [3:0]  ctl [3] = '{4'b0010, 4'b0110, 4'b0001};
        logic [31:0] opa [3] = '{32'd1, 32'd10, 32'h100};
        logic [31:0] opb [3] = '{32'd2, 32'd4, 32'h1};
        logic [31:0] exp [3] = '{32'd3, 32'd6, 32'h101};
        logic [4:0]  tg  [3] = '{5'd11, 5'd12, 5'd13};
        int idx = 0;
        int rx = 0;
        logic acc;
        for (int c = 0; c < 9; c++) begin
            out_ready = (c >= 4);
            if (idx < 3) begin
                in_valid = 1'b1;
                in_ctrl = ctl[idx];
                in_a = opa[idx];
                in_b = opb[idx];
                in_tag = tg[idx];
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (c == 2 || c == 3) begin
                n_chk++;
                if (in_ready !== 1'b0 || out_valid !== 1'b1 ||
                    out_result !== exp[0] || out_tag !== tg[0]) begin
                    n_fail++;
                    $display("FAIL bp_hold c=%0d got rdy=%b v=%b r=%h t=%0d exp rdy=0 v=1 r=%h t=%0d",
                             c, in_ready, out_valid, out_result, out_tag, exp[0], tg[0]);
                end
            end
            if (out_valid && out_ready) begin
                n_chk++;
                if (rx >= 3) begin
                    n_fail++;
                    $display("FAIL bp_extra c=%0d got r=%h t=%0d exp no result", c, out_result, out_tag);
                end else if (out_result !== exp[rx] || out_tag !== tg[rx]) begin
                    n_fail++;
                    $display("FAIL bp_order c=%0d got r=%h t=%0d exp r=%h t=%0d",
                             c, out_result, out_tag, exp[rx], tg[rx]);
                end
                rx++;
            end
            acc = in_valid && in_ready;
            next_cycle();
            if (acc) idx++;
        end
        n_chk++;
        if (rx !== 3 || idx !== 3) begin
            n_fail++;
            $display("FAIL bp_count got rx=%0d acc=%0d exp rx=3 acc=3", rx, idx);
        end
    endtask

    task automatic test_illegal;
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            if (c < 4) begin
                in_valid = 1'b1;
                in_ctrl = (c < 3) ? 4'b0101 : 4'b1111;
                in_a = 32'h1234;
                in_b = 32'h5678;
                in_tag = 5'(c + 16);
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (c >= 2) begin
                n_chk++;
                if (out_valid !== 1'b1 || out_result !== 32'h0 || out_zero !== 1'b1 ||
                    out_illegal !== (c < 5) || out_tag !== 5'(c + 14)) begin
                    n_fail++;
                    $display("FAIL illegal_res c=%0d got v=%b r=%h z=%b i=%b t=%0d exp v=1 r=0 z=1 i=%b t=%0d",
                             c, out_valid, out_result, out_zero, out_illegal, out_tag,
                             (c < 5), c + 14);
                end
            end
            next_cycle();
        end
        @(negedge clk);
        n_chk++;
        if (illegal_cnt !== 16'd3) begin
            n_fail++;
            $display("FAIL illegal_cnt got %0d exp 3", illegal_cnt);
        end
        next_cycle();
    endtask

    task automatic test_flush_reset;
        out_ready = 1'b1;
        for (int c = 0; c < 7; c++) begin
            flush = (c == 2);
            in_valid = (c < 3);
            in_ctrl = (c == 1) ? 4'b0001 : 4'b0010;
            in_a = 32'd2;
            in_b = 32'd3;
            in_tag = 5'(c + 21);
            @(negedge clk);
            if (c == 2) begin
                n_chk++;
                if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_result !== 32'd5) begin
                    n_fail++;
                    $display("FAIL flush_cycle got rdy=%b v=%b r=%h exp rdy=0 v=1 r=5",
                             in_ready, out_valid, out_result);
                end
            end
            if (c >= 3) begin
                n_chk++;
                if (out_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL flush_stale c=%0d got v=%b r=%h exp v=0", c, out_valid, out_result);
                end
            end
            next_cycle();
        end
        flush = 1'b0;
        for (int c = 0; c < 6; c++) begin
            rst = (c == 2);
            in_valid = (c < 3);
            in_ctrl = (c == 1) ? 4'b0100 : 4'b0010;
            in_a = 32'h10;
            in_b = 32'h20;
            in_tag = 5'd7;
            @(negedge clk);
            if (c == 2) begin
                n_chk++;
                if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_result !== 32'h30) begin
                    n_fail++;
                    $display("FAIL rst_mid_cycle got rdy=%b v=%b r=%h exp rdy=0 v=1 r=30",
                             in_ready, out_valid, out_result);
                end
            end
            if (c == 3) begin
                n_chk++;
                if (out_valid !== 1'b0 || out_result !== 32'h0 || out_zero !== 1'b0 ||
                    out_tag !== 5'h0 || out_illegal !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rst_mid_outputs got v=%b r=%h z=%b t=%0d i=%b exp all 0",
                             out_valid, out_result, out_zero, out_tag, out_illegal);
                end
                n_chk++;
                if (illegal_cnt !== 16'h0 || illegal_cnt2 !== 2'h0 || in_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL rst_mid_cnt got cnt=%0d cnt2=%0d rdy=%b exp 0 0 1",
                             illegal_cnt, illegal_cnt2, in_ready);
                end
            end
            if (c >= 4) begin
                n_chk++;
                if (out_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rst_mid_stale c=%0d got v=%b exp 0", c, out_valid);
                end
            end
            next_cycle();
        end
        rst = 1'b0;
    endtask

    task automatic test_saturation;
        logic [3:0] ctl [5] = '{4'b0011, 4'b0100, 4'b0101, 4'b1000, 4'b1110};
        out_ready = 1'b1;
        for (int c = 0; c < 7; c++) begin
            in_valid = (c < 5);
            in_ctrl = ctl[(c < 5) ? c : 0];
            in_a = 32'hAAAA;
            in_b = 32'h5555;
            in_tag = 5'(c);
            @(negedge clk);
            if (c >= 2) begin
                n_chk++;
                if (out_valid !== 1'b1 || out_illegal !== 1'b1 || out_result !== 32'h0) begin
                    n_fail++;
                    $display("FAIL sat_res c=%0d got v=%b i=%b r=%h exp v=1 i=1 r=0",
                             c, out_valid, out_illegal, out_result);
                end
            end
            next_cycle();
        end
        @(negedge clk);
        n_chk++;
        if (illegal_cnt2 !== 2'd3) begin
            n_fail++;
            $display("FAIL sat_cnt2 got %0d exp 3", illegal_cnt2);
        end
        n_chk++;
        if (illegal_cnt !== 16'd5) begin
            n_fail++;
            $display("FAIL sat_cnt16 got %0d exp 5", illegal_cnt);
        end
        next_cycle();
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        test_reset();
        test_back_to_back();
        test_wrap_zero();
        test_back_pressure();
        test_illegal();
        test_flush_reset();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
